// File: rtl/bcd_timer_core.sv
// bcd_timer_core
//   Parametrised BCD up/down timer feeding a 7-segment driver. A prescaled
//   tick steps a packed BCD counter. Each digit has its own modulus, and
//   digits carry upward when counting up and borrow upward when counting
//   down. Counting stops in DONE at the terminal value. ADD/SUBTRACT adjust
//   one digit with saturation. LAP freezes the display. Conflicting strobes,
//   or a REVERSE change while running, latch ERR.
//
// Control inputs
//   START and REVERSE are levels. The other inputs are one-cycle strobes.
//   A strobe acts on the single rising edge that samples it high. There is
//   no back-pressure.
//
// Ports
//   clk_in      in   1         clock, rising edge
//   RESET_N     in   1         asynchronous active-low reset
//   START       in   1         level: 1 = run, 0 = pause
//   REVERSE     in   1         level: 1 = count down, 0 = count up
//   CLEAR       in   1         strobe: reload counter, return to IDLE
//   SPEED_UP    in   1         strobe: SPEED+1, saturating at 3
//   SPEED_DOWN  in   1         strobe: SPEED-1, saturating at 0
//   ADD         in   1         strobe: +1 unit at ADJ_DIGIT (IDLE/PAUSE)
//   SUBTRACT    in   1         strobe: -1 unit at ADJ_DIGIT (IDLE/PAUSE)
//   LAP         in   1         strobe: toggle display freeze (RUN/PAUSE)
//   D_Q         out  4*DIGITS  registered display value
//   SPEED       out  2         current speed level
//   TICK        out  1         pulse on the edge the counter advances
//   RUNNING     out  1         state is RUN
//   DONE        out  1         state is DONE
//   ERROR       out  1         state is ERR
module bcd_timer_core #(
   parameter int                  DIGITS      = 4,
   parameter logic [4*DIGITS-1:0] DIGIT_MAX   = 16'h9599,
   parameter logic [4*DIGITS-1:0] PRESET_DOWN = 16'h4930,
   parameter logic [4*DIGITS-1:0] LIMIT_UP    = 16'h4930,
   parameter int                  ADJ_DIGIT   = 2,
   parameter int                  TICK_DIV    = 2,
   parameter logic [4*DIGITS-1:0] ERR_CODE    = 16'h5555
) (
   input  logic                  clk_in,
   input  logic                  RESET_N,
   input  logic                  START,
   input  logic                  REVERSE,
   input  logic                  CLEAR,
   input  logic                  SPEED_UP,
   input  logic                  SPEED_DOWN,
   input  logic                  ADD,
   input  logic                  SUBTRACT,
   input  logic                  LAP,
   output logic [4*DIGITS-1:0]   D_Q,
   output logic [1:0]            SPEED,
   output logic                  TICK,
   output logic                  RUNNING,
   output logic                  DONE,
   output logic                  ERROR
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE, S_ERR} state_t;

   state_t         state_q, state_n;
   logic [W-1:0]   cnt_q, cnt_n;
   logic [W-1:0]   d_q;
   logic [31:0]    presc_q, presc_n;
   logic [31:0]    period_m1;
   logic [1:0]     speed_q, speed_n;
   logic           lap_q, lap_n;
   logic           tick_q, tick_n;
   logic           rev_q;
   logic [W:0]     step_res;
   logic [W:0]     adj_res;
   logic [W-1:0]   term;
   logic           err_evt;
   logic           adj_ok;
   logic           speed_chg;

   // Steps the counter by one unit at digit k. Digits below k are left
   // alone. The MSB of the result is the carry (or borrow) out of the top
   // digit.
   function automatic logic [W:0] bcd_step(input logic [W-1:0] v,
                                           input logic down, input int k);
      logic [W-1:0] r;
      logic         c;
      logic [3:0]   d;
      logic [3:0]   m;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         m = DIGIT_MAX[4*i +: 4];
         if (i >= k && c) begin
            if (!down) begin
               if (d >= m) begin r[4*i +: 4] = 4'd0;       c = 1'b1; end
               else        begin r[4*i +: 4] = d + 4'd1;   c = 1'b0; end
            end else begin
               if (d == 4'd0) begin r[4*i +: 4] = m;        c = 1'b1; end
               else           begin r[4*i +: 4] = d - 4'd1; c = 1'b0; end
            end
         end
      end
      return {c, r};
   endfunction

   assign step_res  = bcd_step(cnt_q, REVERSE, 0);
   assign adj_res   = bcd_step(cnt_q, SUBTRACT, ADJ_DIGIT);
   assign term      = REVERSE ? '0 : LIMIT_UP;
   assign period_m1 = (32'(TICK_DIV) << (2'd3 - speed_q)) - 32'd1;
   assign speed_chg = SPEED_UP ^ SPEED_DOWN;
   assign adj_ok    = (ADD ^ SUBTRACT) && (state_q == S_IDLE || state_q == S_PAUSE);
   assign err_evt   = (SPEED_UP && SPEED_DOWN) || (ADD && SUBTRACT) ||
                      (state_q == S_RUN && REVERSE != rev_q);

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      presc_n = presc_q;
      speed_n = speed_q;
      lap_n   = lap_q;
      tick_n  = 1'b0;
      if (CLEAR) begin
         cnt_n   = REVERSE ? PRESET_DOWN : '0;
         presc_n = '0;
         lap_n   = 1'b0;
         state_n = S_IDLE;
      end else if (err_evt) begin
         state_n = S_ERR;
         presc_n = '0;
      end else begin
         case (state_q)
            S_IDLE:  if (START)  state_n = S_RUN;
            S_RUN:   if (!START) state_n = S_PAUSE;
            S_PAUSE: if (START)  state_n = S_RUN;
            default: ;
         endcase
         if (LAP && (state_q == S_RUN || state_q == S_PAUSE))
            lap_n = !lap_q;
         if (adj_ok) begin
            // Overflow past the top digit clamps to all-max, underflow to zero.
            if (adj_res[W]) cnt_n = SUBTRACT ? '0 : DIGIT_MAX;
            else            cnt_n = adj_res[W-1:0];
         end else if (speed_chg) begin
            if (SPEED_UP && speed_q != 2'd3)   speed_n = speed_q + 2'd1;
            if (SPEED_DOWN && speed_q != 2'd0) speed_n = speed_q - 2'd1;
            if (speed_n != speed_q)            presc_n = '0;
         end else if (state_q == S_RUN && START) begin
            if (presc_q == period_m1) begin
               presc_n = '0;
               cnt_n   = step_res[W-1:0];
               tick_n  = 1'b1;
               // Compare against the stepped value so DONE lands on the final
               // tick and the counter never passes the terminal value.
               if (step_res[W-1:0] == term) state_n = S_DONE;
            end else begin
               presc_n = presc_q + 32'd1;
            end
         end
         if (state_n != S_RUN) presc_n = '0;
      end
   end

   always_ff @(posedge clk_in or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         presc_q <= '0;
         speed_q <= 2'd2;
         lap_q   <= 1'b0;
         tick_q  <= 1'b0;
         rev_q   <= 1'b0;
         d_q     <= '0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         presc_q <= presc_n;
         speed_q <= speed_n;
         lap_q   <= lap_n;
         tick_q  <= tick_n;
         rev_q   <= REVERSE;
         // The display follows the registered counter one edge later. It is
         // held while lap-frozen and shows the error code while in ERR.
         if (state_q == S_ERR) d_q <= ERR_CODE;
         else if (!lap_q)      d_q <= cnt_q;
      end
   end

   assign D_Q     = d_q;
   assign SPEED   = speed_q;
   assign TICK    = tick_q;
   assign RUNNING = (state_q == S_RUN);
   assign DONE    = (state_q == S_DONE);
   assign ERROR   = (state_q == S_ERR);

endmodule

// File: tb/tb_bcd_timer_core.sv
// tb_bcd_timer_core
//   Directed bench for bcd_timer_core configured as an MM:SS timer. Digit
//   moduli are 9,5,9,9 from digit 0 upward, which gives a 99:59 ceiling.
//   Expected display values come from a seconds-based model (to_bcd), not
//   from BCD digit arithmetic.
module tb_bcd_timer_core;

   logic        clk_in = 1'b0;
   logic        RESET_N, START, REVERSE, CLEAR, SPEED_UP, SPEED_DOWN, ADD, SUBTRACT, LAP;
   logic [15:0] D_Q;
   logic [1:0]  SPEED;
   logic        TICK, RUNNING, DONE, ERROR;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [5:0] S_CLR = 6'b100000;
   localparam logic [5:0] S_SU  = 6'b010000;
   localparam logic [5:0] S_SD  = 6'b001000;
   localparam logic [5:0] S_ADD = 6'b000100;
   localparam logic [5:0] S_SUB = 6'b000010;
   localparam logic [5:0] S_LAP = 6'b000001;

   typedef struct {
      string       name;
      logic [5:0]  strb;
      int          reps;
      logic        rev;
      logic [15:0] dq;
      logic [1:0]  spd;
      logic        err;
   } vec_t;

   vec_t        vecs[$];
   logic [15:0] exp_q[$];

   bcd_timer_core #(.DIGIT_MAX(16'h9959)) dut (
      .clk_in(clk_in), .RESET_N(RESET_N), .START(START), .REVERSE(REVERSE),
      .CLEAR(CLEAR), .SPEED_UP(SPEED_UP), .SPEED_DOWN(SPEED_DOWN), .ADD(ADD),
      .SUBTRACT(SUBTRACT), .LAP(LAP), .D_Q(D_Q), .SPEED(SPEED), .TICK(TICK),
      .RUNNING(RUNNING), .DONE(DONE), .ERROR(ERROR)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk_in = ~clk_in;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int s);
      int m;
      int ss;
      m  = s / 60;
      ss = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic pulse(input logic [5:0] m);
      {CLEAR, SPEED_UP, SPEED_DOWN, ADD, SUBTRACT, LAP} = m;
      step(1);
      {CLEAR, SPEED_UP, SPEED_DOWN, ADD, SUBTRACT, LAP} = 6'b0;
   endtask

   task automatic wait_tick(input string nm, output int n);
      n = 0;
      do begin
         step(1);
         n++;
      end while (!TICK && n < 40);
      check({nm, "_tick_seen"}, 32'(TICK), 32'd1);
   endtask

   task automatic count_ticks(input int cycles, output int cnt);
      cnt = 0;
      repeat (cycles) begin
         step(1);
         if (TICK) cnt++;
      end
   endtask

   task automatic add_vec(input string nm, input logic [5:0] s, input int r, input logic rv,
                          input logic [15:0] dq, input logic [1:0] sp, input logic er);
      vec_t v;
      v.name = nm; v.strb = s; v.reps = r; v.rev = rv;
      v.dq = dq; v.spd = sp; v.err = er;
      vecs.push_back(v);
   endtask

   // ---------------- test ----------------
   initial begin
      int n;
      int secs;
      int extra;
      logic [15:0] e;

      RESET_N = 1'b0; START = 1'b0; REVERSE = 1'b0;
      {CLEAR, SPEED_UP, SPEED_DOWN, ADD, SUBTRACT, LAP} = 6'b0;
      step(3);
      RESET_N = 1'b1;
      step(1);
      check("rst_dq",      32'(D_Q),     32'h0);
      check("rst_speed",   32'(SPEED),   32'd2);
      check("rst_tick",    32'(TICK),    32'd0);
      check("rst_running", 32'(RUNNING), 32'd0);
      check("rst_done",    32'(DONE),    32'd0);
      check("rst_error",   32'(ERROR),   32'd0);

      // Adjust, saturation, speed and error vectors, all applied with START=0
      add_vec("add_x9",      S_ADD,        9, 1'b0, 16'h0900, 2'd2, 1'b0);
      add_vec("add_carry",   S_ADD,        2, 1'b0, 16'h1100, 2'd2, 1'b0);
      add_vec("sub_x11",     S_SUB,       11, 1'b0, 16'h0000, 2'd2, 1'b0);
      add_vec("sub_clamp",   S_SUB,        1, 1'b0, 16'h0000, 2'd2, 1'b0);
      add_vec("add_x99",     S_ADD,       99, 1'b0, 16'h9900, 2'd2, 1'b0);
      add_vec("add_sat",     S_ADD,        3, 1'b0, 16'h9959, 2'd2, 1'b0);
      add_vec("sub_max",     S_SUB,        1, 1'b0, 16'h9859, 2'd2, 1'b0);
      add_vec("spd_up3",     S_SU,         3, 1'b0, 16'h9859, 2'd3, 1'b0);
      add_vec("spd_dn5",     S_SD,         5, 1'b0, 16'h9859, 2'd0, 1'b0);
      add_vec("spd_up2",     S_SU,         2, 1'b0, 16'h9859, 2'd2, 1'b0);
      add_vec("err_addsub",  S_ADD|S_SUB,  1, 1'b0, 16'h5555, 2'd2, 1'b1);
      add_vec("err_clear",   S_CLR,        1, 1'b0, 16'h0000, 2'd2, 1'b0);
      add_vec("err_spd",     S_SU|S_SD,    1, 1'b0, 16'h5555, 2'd2, 1'b1);
      add_vec("rev_clear",   S_CLR,        1, 1'b1, 16'h4930, 2'd2, 1'b0);
      add_vec("clear_up",    S_CLR,        1, 1'b0, 16'h0000, 2'd2, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         REVERSE = vecs[i].rev;
         repeat (vecs[i].reps) pulse(vecs[i].strb);
         step(1);
         check({vecs[i].name, "_dq"},    32'(D_Q),   32'(vecs[i].dq));
         check({vecs[i].name, "_speed"}, 32'(SPEED), 32'(vecs[i].spd));
         check({vecs[i].name, "_error"}, 32'(ERROR), 32'(vecs[i].err));
      end

      // Count up from 00:00 through 01:00, period 4 at SPEED 2
      for (int k = 1; k <= 60; k++) exp_q.push_back(to_bcd(k));
      START = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         wait_tick("up", n);
         if (k > 1) check("up_period", 32'(n), 32'd3);
         step(1);
         if (k == 1) check("tick_width", 32'(TICK), 32'd0);
         e = exp_q.pop_front();
         check("up_dq", 32'(D_Q), 32'(e));
      end

      // Lap freeze at 00:12, release at 00:20
      START = 1'b0;
      step(1);
      pulse(S_CLR);
      START = 1'b1;
      for (int k = 1; k <= 12; k++) wait_tick("lap_run", n);
      pulse(S_LAP);
      check("lap_freeze", 32'(D_Q), 32'h0012);
      for (int k = 13; k <= 20; k++) begin
         wait_tick("lap_cont", n);
         check("lap_hold", 32'(D_Q), 32'h0012);
      end
      pulse(S_LAP);
      step(1);
      check("lap_release", 32'(D_Q), 32'h0020);

      // Count up to LIMIT_UP 49:30 from 49:00
      START = 1'b0;
      step(1);
      pulse(S_CLR);
      repeat (49) pulse(S_ADD);
      START = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         wait_tick("term_up", n);
         if (k == 29) check("no_early_done", 32'(DONE), 32'd0);
      end
      check("done_up",       32'(DONE),    32'd1);
      check("done_up_run",   32'(RUNNING), 32'd0);
      step(1);
      check("done_up_dq",    32'(D_Q),     32'h4930);
      count_ticks(40, extra);
      check("done_up_noticks", 32'(extra), 32'd0);
      check("done_up_hold",  32'(D_Q),     32'h4930);
      START = 1'b0;
      pulse(S_CLR);
      check("done_clear",    32'(DONE),    32'd0);

      // Count down from PRESET_DOWN 49:30; ADD while running is ignored
      REVERSE = 1'b1;
      pulse(S_CLR);
      START = 1'b1;
      secs = 49 * 60 + 30;
      for (int k = 1; k <= 31; k++) begin
         wait_tick("down", n);
         secs--;
         step(1);
         check("down_dq", 32'(D_Q), 32'(to_bcd(secs)));
         if (k == 1) pulse(S_ADD);
      end
      check("down_4859", 32'(D_Q), 32'h4859);
      START = 1'b0;
      step(1);
      repeat (48) pulse(S_SUB);
      step(1);
      check("sub_in_pause", 32'(D_Q), 32'h0059);
      secs = 59;
      START = 1'b1;
      for (int k = 1; k <= 59; k++) begin
         wait_tick("down_end", n);
         secs--;
         if (k == 58) check("down_not_done", 32'(DONE), 32'd0);
         step(1);
         check("down_end_dq", 32'(D_Q), 32'(to_bcd(secs)));
      end
      check("done_down",     32'(DONE),    32'd1);
      check("done_down_run", 32'(RUNNING), 32'd0);
      count_ticks(20, extra);
      check("done_down_noticks", 32'(extra), 32'd0);
      check("done_down_hold", 32'(D_Q), 32'h0000);
      START = 1'b0;
      pulse(S_CLR);
      step(1);
      check("down_reload", 32'(D_Q),  32'h4930);
      check("down_clear",  32'(DONE), 32'd0);

      // REVERSE toggled while running latches ERR
      START = 1'b1;
      wait_tick("rev_err", n);
      REVERSE = 1'b0;
      step(1);
      check("rev_err_flag", 32'(ERROR),   32'd1);
      check("rev_err_run",  32'(RUNNING), 32'd0);
      step(1);
      check("rev_err_dq",   32'(D_Q),     32'h5555);
      count_ticks(20, extra);
      check("err_noticks",  32'(extra),   32'd0);
      check("err_sticky",   32'(ERROR),   32'd1);
      START = 1'b0;
      pulse(S_CLR);
      step(1);
      check("err_clr_flag", 32'(ERROR),   32'd0);
      check("err_clr_dq",   32'(D_Q),     32'h0000);

      // Prescaler periods at SPEED 3 and 0, then asynchronous reset mid-run
      pulse(S_SU);
      check("spd3", 32'(SPEED), 32'd3);
      START = 1'b1;
      wait_tick("spd3_a", n);
      wait_tick("spd3_b", n);
      check("period_spd3", 32'(n), 32'd2);
      repeat (3) pulse(S_SD);
      check("spd0", 32'(SPEED), 32'd0);
      wait_tick("spd0_a", n);
      wait_tick("spd0_b", n);
      check("period_spd0", 32'(n), 32'd16);
      RESET_N = 1'b0;
      #1;
      check("arst_dq",      32'(D_Q),     32'h0);
      check("arst_tick",    32'(TICK),    32'd0);
      check("arst_running", 32'(RUNNING), 32'd0);
      check("arst_done",    32'(DONE),    32'd0);
      check("arst_error",   32'(ERROR),   32'd0);
      check("arst_speed",   32'(SPEED),   32'd2);
      START = 1'b0;
      RESET_N = 1'b1;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
